// File: rtl/led_pio_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// led_pio_sequencer_pkg : register map, CTRL bit positions, FSM and grant types
// Revision: 1.0
// ============================================================================
package led_pio_sequencer_pkg;

  localparam int CFG_ADDR_W = 3;
  localparam int STEP_W     = 3;

  localparam logic [CFG_ADDR_W-1:0] ADDR_CTRL   = 3'd0;
  localparam logic [CFG_ADDR_W-1:0] ADDR_PERIOD = 3'd1;
  localparam logic [CFG_ADDR_W-1:0] ADDR_STATUS = 3'd7;
  localparam int                    PATTERN_BASE = 2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_BUSY    = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEQ_WR = 2'd1,
    ST_OVR_WR = 2'd2
  } fsm_state_t;

  typedef enum logic {
    GRANT_SEQ = 1'b0,
    GRANT_OVR = 1'b1
  } grant_t;

endpackage
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
// led_tick_gen : free-running period counter emitting a one-cycle tick
// Revision: 1.0
// ============================================================================
module led_tick_gen #(
  parameter int PERIOD_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] terminal;

  // A period of 0 behaves as 1; >= also recovers if PERIOD shrinks below count.
  assign terminal = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign tick     = en && (count >= terminal);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!en || tick) begin
      count <= '0;
    end else begin
      count <= count + PERIOD_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_pio_sequencer.sv
`default_nettype none
// ============================================================================
// led_pio_sequencer : pattern sequencer and override arbiter owning the LED PIO
// Revision: 1.0
// ============================================================================
module led_pio_sequencer
  import led_pio_sequencer_pkg::*;
#(
  parameter int NUM_STEPS      = 4,
  parameter int PERIOD_W       = 32,
  parameter int DEFAULT_PERIOD = 50000000,
  parameter int LED_W          = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CFG_ADDR_W-1:0] cfg_address,
  input  logic                  cfg_chipselect,
  input  logic                  cfg_write_n,
  input  logic [31:0]           cfg_writedata,
  output logic [31:0]           cfg_readdata,
  input  logic                  ovr_req,
  input  logic [LED_W-1:0]      ovr_data,
  output logic                  ovr_ack,
  output logic [1:0]            pio_address,
  output logic                  pio_chipselect,
  output logic                  pio_write_n,
  output logic [31:0]           pio_writedata
);

  logic                ctrl_en;
  logic                ctrl_oneshot;
  logic [PERIOD_W-1:0] period;
  logic [LED_W-1:0]    pattern [NUM_STEPS];
  logic [STEP_W-1:0]   step;
  logic [STEP_W-1:0]   step_inc;
  logic                seq_pending;
  logic [LED_W-1:0]    last_written;
  grant_t              last_grant;
  fsm_state_t          state;
  fsm_state_t          state_next;

  logic                tick;
  logic                cfg_wr;
  logic                ctrl_wr;
  logic                en_rise;
  logic                en_clear;
  logic                seq_req;
  logic                oneshot_done;
  logic                busy;
  logic [LED_W-1:0]    seq_value;
  logic [LED_W-1:0]    wr_value;
  logic [31:0]         ctrl_rd;
  logic [31:0]         status_rd;

  led_tick_gen #(
    .PERIOD_W (PERIOD_W)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (ctrl_en),
    .period  (period),
    .tick    (tick)
  );

  assign cfg_wr   = cfg_chipselect && !cfg_write_n;
  assign ctrl_wr  = cfg_wr && (cfg_address == ADDR_CTRL);
  assign en_rise  = ctrl_wr && cfg_writedata[CTRL_EN] && !ctrl_en;
  assign en_clear = ctrl_wr && !cfg_writedata[CTRL_EN];

  // Same-cycle tick/enable counts as pending so an idle FSM issues the write next cycle.
  assign seq_req = en_rise || ((seq_pending || tick) && !en_clear);

  assign oneshot_done = (state == ST_SEQ_WR) && ctrl_en && ctrl_oneshot &&
                        (step == STEP_W'(NUM_STEPS - 1));
  assign step_inc     = (step == STEP_W'(NUM_STEPS - 1)) ? '0 : step + STEP_W'(1);
  assign busy         = (state != ST_IDLE) || seq_pending;

  always_comb begin
    seq_value = '0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (step == STEP_W'(i)) seq_value = pattern[i];
    end
  end

  assign wr_value = (state == ST_OVR_WR) ? ovr_data : seq_value;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (ovr_req && (!seq_req || last_grant == GRANT_SEQ)) state_next = ST_OVR_WR;
        else if (seq_req)                                     state_next = ST_SEQ_WR;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en      <= 1'b0;
      ctrl_oneshot <= 1'b0;
      period       <= PERIOD_W'(DEFAULT_PERIOD);
      for (int i = 0; i < NUM_STEPS; i++) pattern[i] <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl_en      <= cfg_writedata[CTRL_EN];
        ctrl_oneshot <= cfg_writedata[CTRL_ONESHOT];
      end else if (oneshot_done) begin
        ctrl_en <= 1'b0;
      end
      if (cfg_wr && cfg_address == ADDR_PERIOD) period <= cfg_writedata[PERIOD_W-1:0];
      for (int i = 0; i < NUM_STEPS; i++) begin
        if (cfg_wr && cfg_address == CFG_ADDR_W'(PATTERN_BASE + i))
          pattern[i] <= cfg_writedata[LED_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step        <= '0;
      seq_pending <= 1'b0;
    end else if (en_rise) begin
      step        <= '0;
      seq_pending <= 1'b1;
    end else if (!ctrl_en || en_clear || oneshot_done) begin
      step        <= '0;
      seq_pending <= 1'b0;
    end else if (tick) begin
      step        <= step_inc;
      seq_pending <= 1'b1;
    end else if (state == ST_SEQ_WR) begin
      seq_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_written <= '0;
      last_grant   <= GRANT_SEQ;
    end else if (state != ST_IDLE) begin
      last_written <= wr_value;
      last_grant   <= (state == ST_OVR_WR) ? GRANT_OVR : GRANT_SEQ;
    end
  end

  assign pio_address    = 2'b00;
  assign pio_chipselect = (state != ST_IDLE);
  assign pio_write_n    = !pio_chipselect;
  assign pio_writedata  = pio_chipselect ? 32'(wr_value) : 32'h0;
  assign ovr_ack        = (state == ST_OVR_WR);

  always_comb begin
    ctrl_rd               = '0;
    ctrl_rd[CTRL_EN]      = ctrl_en;
    ctrl_rd[CTRL_ONESHOT] = ctrl_oneshot;
    ctrl_rd[CTRL_BUSY]    = busy;
  end

  assign status_rd = 32'({seq_pending, step, 8'(last_written)});

  always_comb begin
    cfg_readdata = '0;
    case (cfg_address)
      ADDR_CTRL:   cfg_readdata = ctrl_rd;
      ADDR_PERIOD: cfg_readdata = 32'(period);
      ADDR_STATUS: cfg_readdata = status_rd;
      default: begin
        for (int i = 0; i < NUM_STEPS; i++) begin
          if (cfg_address == CFG_ADDR_W'(PATTERN_BASE + i)) cfg_readdata = 32'(pattern[i]);
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pio_sequencer.sv
`default_nettype none
// ============================================================================
// tb_led_pio_sequencer : scenario tasks checked against spec-derived expectations
// Revision: 1.0
// ============================================================================
module tb_led_pio_sequencer;
  import led_pio_sequencer_pkg::*;

  localparam int NUM_STEPS      = 4;
  localparam int PERIOD_W       = 32;
  localparam int DEFAULT_PERIOD = 50000000;
  localparam int LED_W          = 8;

  logic        clk            = 1'b0;
  logic        reset_n        = 1'b0;
  logic [2:0]  cfg_address    = '0;
  logic        cfg_chipselect = 1'b0;
  logic        cfg_write_n    = 1'b1;
  logic [31:0] cfg_writedata  = '0;
  logic [31:0] cfg_readdata;
  logic        ovr_req        = 1'b0;
  logic [7:0]  ovr_data       = '0;
  logic        ovr_ack;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  pat [NUM_STEPS];
  logic [7:0]  model_last = '0;

  led_pio_sequencer #(
    .NUM_STEPS      (NUM_STEPS),
    .PERIOD_W       (PERIOD_W),
    .DEFAULT_PERIOD (DEFAULT_PERIOD),
    .LED_W          (LED_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_address    (cfg_address),
    .cfg_chipselect (cfg_chipselect),
    .cfg_write_n    (cfg_write_n),
    .cfg_writedata  (cfg_writedata),
    .cfg_readdata   (cfg_readdata),
    .ovr_req        (ovr_req),
    .ovr_data       (ovr_data),
    .ovr_ack        (ovr_ack),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_address    = a;
    cfg_writedata  = d;
    cfg_chipselect = 1'b1;
    cfg_write_n    = 1'b0;
    next_cycle();
    cfg_chipselect = 1'b0;
    cfg_write_n    = 1'b1;
  endtask

  task automatic cfg_read(input logic [2:0] a, output logic [31:0] d);
    cfg_address = a;
    #1;
    d = cfg_readdata;
  endtask

  task automatic program_patterns();
    for (int i = 0; i < NUM_STEPS; i++) begin
      pat[i] = 8'($urandom_range(1, 254));
      if (pat[i] == 8'hAA) pat[i] = 8'h55;
      cfg_write(3'(PATTERN_BASE + i), {24'h0, pat[i]});
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (2) next_cycle();
    checks++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_address !== 2'b00 || ovr_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes got cs=%b wn=%b addr=%b ack=%b want 0 1 00 0",
               pio_chipselect, pio_write_n, pio_address, ovr_ack);
    end
    checks++;
    if (pio_writedata !== 32'h0) begin
      errors++; $display("FAIL reset_writedata got %h want 0", pio_writedata);
    end
    cfg_read(ADDR_CTRL, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", d); end
    cfg_read(ADDR_PERIOD, d);
    checks++;
    if (d !== 32'(DEFAULT_PERIOD)) begin
      errors++; $display("FAIL reset_period got %0d want %0d", d, DEFAULT_PERIOD);
    end
    cfg_read(ADDR_STATUS, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", d); end
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_sequence();
    int          p;
    logic [31:0] d;
    logic        exp_wr;
    logic [7:0]  exp_val;
    program_patterns();
    cfg_read(3'(PATTERN_BASE + 1), d);
    checks++;
    if (d !== {24'h0, pat[1]}) begin errors++; $display("FAIL pattern_readback got %h want %h", d, pat[1]); end
    cfg_read(3'd6, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h want 0", d); end
    p = $urandom_range(2, 5);
    cfg_write(ADDR_PERIOD, 32'(p));
    cfg_write(ADDR_CTRL, 32'h1);
    for (int k = 0; k <= 4 * p; k++) begin
      cfg_address = ADDR_STATUS;
      #1;
      exp_wr  = (k % p == 0);
      exp_val = pat[(k / p) % NUM_STEPS];
      checks++;
      if (pio_chipselect !== exp_wr || pio_write_n !== !exp_wr || ovr_ack !== 1'b0) begin
        errors++;
        $display("FAIL seq_strobe k=%0d got cs=%b wn=%b ack=%b want cs=%b", k, pio_chipselect, pio_write_n, ovr_ack, exp_wr);
      end
      if (exp_wr) begin
        checks++;
        if (pio_writedata !== {24'h0, exp_val}) begin
          errors++; $display("FAIL seq_data k=%0d got %h want %h", k, pio_writedata, exp_val);
        end
      end
      checks++;
      if (cfg_readdata[7:0] !== model_last) begin
        errors++; $display("FAIL seq_status_last k=%0d got %h want %h", k, cfg_readdata[7:0], model_last);
      end
      if (exp_wr) model_last = exp_val;
      next_cycle();
    end
    cfg_write(ADDR_CTRL, 32'h0);
  endtask

  task automatic test_oneshot();
    int          p;
    logic [31:0] d;
    logic        exp_wr;
    p = $urandom_range(2, 4);
    cfg_write(ADDR_PERIOD, 32'(p));
    cfg_write(ADDR_CTRL, 32'h3);
    for (int k = 0; k <= 3 * p + 12; k++) begin
      #1;
      exp_wr = (k % p == 0) && (k / p < NUM_STEPS);
      checks++;
      if (pio_chipselect !== exp_wr || ovr_ack !== 1'b0) begin
        errors++; $display("FAIL oneshot_strobe k=%0d got cs=%b ack=%b want cs=%b", k, pio_chipselect, ovr_ack, exp_wr);
      end
      if (exp_wr) begin
        checks++;
        if (pio_writedata !== {24'h0, pat[k / p]}) begin
          errors++; $display("FAIL oneshot_data k=%0d got %h want %h", k, pio_writedata, pat[k / p]);
        end
        model_last = pat[k / p];
      end
      next_cycle();
    end
    cfg_read(ADDR_CTRL, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL oneshot_ctrl got %h want 2", d); end
    cfg_read(ADDR_STATUS, d);
    checks++;
    if (d !== {20'h0, 1'b0, 3'd0, model_last}) begin
      errors++; $display("FAIL oneshot_status got %h want %h", d, {20'h0, 1'b0, 3'd0, model_last});
    end
  endtask

  task automatic test_alternate();
    logic       exp_wr;
    logic       exp_ovr;
    logic [7:0] exp_val;
    program_patterns();
    ovr_data = 8'hAA;
    cfg_write(ADDR_PERIOD, 32'h0);
    ovr_req = 1'b1;
    cfg_write(ADDR_CTRL, 32'h1);
    for (int k = 0; k < 24; k++) begin
      cfg_address = ADDR_STATUS;
      #1;
      exp_wr  = (k % 2 == 0);
      exp_ovr = exp_wr && ((k / 2) % 2 == 0);
      exp_val = exp_ovr ? 8'hAA : pat[k % NUM_STEPS];
      checks++;
      if (pio_chipselect !== exp_wr || ovr_ack !== exp_ovr) begin
        errors++; $display("FAIL alt_strobe k=%0d got cs=%b ack=%b want cs=%b ack=%b", k, pio_chipselect, ovr_ack, exp_wr, exp_ovr);
      end
      if (exp_wr) begin
        checks++;
        if (pio_writedata !== {24'h0, exp_val}) begin
          errors++; $display("FAIL alt_data k=%0d got %h want %h", k, pio_writedata, exp_val);
        end
      end
      checks++;
      if (cfg_readdata[11:0] !== {1'b1, 3'(k % NUM_STEPS), model_last}) begin
        errors++; $display("FAIL alt_status k=%0d got %h want %h", k, cfg_readdata[11:0], {1'b1, 3'(k % NUM_STEPS), model_last});
      end
      if (exp_wr) model_last = exp_val;
      next_cycle();
    end
  endtask

  task automatic test_en_clear();
    logic exp_wr;
    checks++;
    if (ovr_ack !== 1'b1 || pio_writedata !== 32'hAA) begin
      errors++; $display("FAIL clr_setup got ack=%b data=%h want 1 000000aa", ovr_ack, pio_writedata);
    end
    model_last = 8'hAA;
    cfg_write(ADDR_CTRL, 32'h0);
    for (int k = 0; k < 12; k++) begin
      cfg_address = ADDR_STATUS;
      #1;
      exp_wr = (k % 2 == 1);
      checks++;
      if (pio_chipselect !== exp_wr || ovr_ack !== exp_wr) begin
        errors++; $display("FAIL clr_strobe k=%0d got cs=%b ack=%b want %b", k, pio_chipselect, ovr_ack, exp_wr);
      end
      if (exp_wr) begin
        checks++;
        if (pio_writedata !== 32'hAA) begin
          errors++; $display("FAIL clr_data k=%0d got %h want aa", k, pio_writedata);
        end
      end
      checks++;
      if (cfg_readdata[11:0] !== {1'b0, 3'd0, model_last}) begin
        errors++; $display("FAIL clr_status k=%0d got %h want %h", k, cfg_readdata[11:0], {1'b0, 3'd0, model_last});
      end
      next_cycle();
    end
    ovr_req = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d;
    cfg_write(ADDR_PERIOD, 32'd1000);
    cfg_write(ADDR_CTRL, 32'h1);
    checks++;
    if (pio_chipselect !== 1'b1 || pio_writedata !== {24'h0, pat[0]}) begin
      errors++; $display("FAIL rst_setup got cs=%b data=%h want 1 %h", pio_chipselect, pio_writedata, pat[0]);
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || ovr_ack !== 1'b0 || pio_writedata !== 32'h0) begin
      errors++;
      $display("FAIL rst_async got cs=%b wn=%b ack=%b data=%h want 0 1 0 0", pio_chipselect, pio_write_n, ovr_ack, pio_writedata);
    end
    cfg_read(ADDR_CTRL, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl got %h want 0", d); end
    cfg_read(ADDR_PERIOD, d);
    checks++;
    if (d !== 32'(DEFAULT_PERIOD)) begin errors++; $display("FAIL rst_period got %0d want %0d", d, DEFAULT_PERIOD); end
    cfg_read(3'(PATTERN_BASE), d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_pattern got %h want 0", d); end
    cfg_read(ADDR_STATUS, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_status got %h want 0", d); end
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (pio_chipselect !== 1'b0) begin
        errors++; $display("FAIL rst_quiet k=%0d got cs=%b want 0", k, pio_chipselect);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_oneshot();
    test_alternate();
    test_en_clear();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
